pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in system-clock cycles, plus a lock indication and a stuck-line flag. It is the receive end of the PWM link the adhoc generator drives on JA[0]. It sits on a PMOD input of a second board, or on a loopback input of the same board, and is used for closed-loop checking of generated duty cycles at the 10 MHz, 5 MHz and 1 MHz settings.

## Interface
- WIDTH, 8, width of the period and high-time counters and outputs
- SYNC_STAGES, 2, number of input synchronizer flops (minimum 2)
- clk  in  1  system clock (100 MHz on the board)
- srst  in  1  synchronous reset, active-high
- pwm_in  in  1  asynchronous PWM input
- period_out  out  WIDTH  cycles between the last two rising edges
- high_out  out  WIDTH  cycles the input was high within that period
- meas_valid  out  1  one-cycle pulse; period_out/high_out updated this cycle
- locked  out  1  two consecutive identical measurements
- stuck  out  1  one-cycle pulse on timeout (no rising edge for 2^WIDTH−1 cycles)
- stuck_level  out  1  synchronized input level at the last timeout

One clock domain is used; reset is synchronous and active-high.

## Operation
- The synchronizer chain is reset to 0. `prev` holds the previous synchronized sample. `rise = sync & ~prev`.
- FSM states:
  - IDLE: waits for sync==0, then goes to ARMED. This prevents a false edge after reset while pwm_in is high.
  - ARMED: on `rise`, goes to MEAS and sets cnt_p=1, cnt_h=1. No output is produced.
  - MEAS: each cycle, cnt_p+=1 and cnt_h+=sync. On `rise`, it publishes period_out=cnt_p and high_out=cnt_h, pulses meas_valid, reloads cnt_p=1 and cnt_h=1, and stays in MEAS.
- Timeout: tmo counter runs in all states, clears on `rise` and on entry to IDLE, and saturates at 2^WIDTH−1. On reaching that value:
  - stuck pulses.
  - stuck_level = sync.
  - period_out and high_out are cleared to 0.
  - locked is cleared and the FSM goes to IDLE.
  - A stuck-high line therefore remains in IDLE until it goes low.
- A measurement whose cnt_p would exceed 2^WIDTH−1 is handled by the timeout and is never published. This means the maximum reportable period is 2^WIDTH−2.
- Lock:
  - On each publish, the block compares the new (period, high) pair with the previous published pair.
  - A match sets locked. A mismatch clears locked.
  - The first publish after reset or timeout only stores the pair; locked stays 0.
- 0 % and 100 % duty produce no rising edges. They are reported via stuck with stuck_level 0 or 1 respectively.
- Minimum measurable waveform: synchronized high ≥1 cycle and low ≥1 cycle, i.e. period ≥2. Narrower pulses may be dropped. This is not an error condition.

## Timing
- Reset values: period_out=0, high_out=0, meas_valid=0, locked=0, stuck=0, stuck_level=0, state IDLE, all counters 0.
- srst mid-measurement discards the partial count. The first publish after srst needs a low level, then two rising edges.
- Latency, with SYNC_STAGES=2: let edge k be the first clk edge that samples pwm_in high. Then:
  - `rise` is true in the cycle after edge k+1.
  - meas_valid is high in the cycle after edge k+2, with period_out and high_out valid in that same cycle.
  - Each extra sync stage adds 1 cycle.
- meas_valid is never high for two consecutive cycles. stuck and meas_valid are never high in the same cycle.
- locked changes only on the edge that raises meas_valid, or on timeout, or on srst.
- If `rise` and tmo saturation coincide, `rise` wins: the result is published and no timeout occurs.

## Test plan
- Period 10, high 5 (10 MHz setting) -> first meas_valid on the second rising edge, with period_out=10 and high_out=5. meas_valid then repeats every 10 cycles. locked=1 from the second publish onward.
- Duty step from high 5 to high 6 at a period boundary -> one publish with high_out=6 and locked=0. The next publish has high_out=6 and locked=1.
- Period 100, high 1 (1 MHz, minimum duty) -> period_out=100, high_out=1. Then period 2, high 1 -> period_out=2, high_out=1.
- pwm_in held high for 300 cycles with WIDTH=8 -> stuck pulses once, 255 cycles after the last `rise`. stuck_level=1, period_out=0, locked=0, no meas_valid. After release, two more edges are needed before the next publish.
- srst asserted mid-period with pwm_in high -> all outputs are 0 the next cycle. No publish occurs until low, rise, rise. The first publish has the correct period and locked=0.
- Rising edge arriving on the exact cycle tmo reaches 254→255 boundary, i.e. a period of 255 cycles -> no publish and stuck pulses. A period of 254 cycles -> publish with period_out=254 and no stuck.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Measurement result bus of pwm_capture: period/high-time results plus lock and
// stuck-line status, driven by the capture block and read by its consumer.
interface pwm_capture_if #(
  parameter int WIDTH = 8
);
  // meas_valid is a one-cycle strobe with no backpressure: period_out/high_out
  // change only in a meas_valid cycle and the consumer must take them then.
  // stuck is likewise a one-cycle strobe and never coincides with meas_valid.
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] high_out;
  logic             meas_valid;
  logic             locked;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output period_out,
    output high_out,
    output meas_valid,
    output locked,
    output stuck,
    output stuck_level
  );

  modport slave (
    input period_out,
    input high_out,
    input meas_valid,
    input locked,
    input stuck,
    input stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time between consecutive rising edges
// of an asynchronous input, flags lock on repeated results and stuck lines.
module pwm_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          pwm_in,
  pwm_capture_if.master meas,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_MEAS  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TMO_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  // Input synchronizer. fill_q tracks which stages hold real samples so that
  // the reset zeros in the chain are never mistaken for a low input level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   sync;
  logic                   sync_ok;
  logic                   rise;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync;
    end
  end

  assign sync    = sync_q[SYNC_STAGES-1];
  assign sync_ok = fill_q[SYNC_STAGES-1];
  assign rise    = sync & ~prev_q;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_p_q, cnt_p_d;
  logic [WIDTH-1:0] cnt_h_q, cnt_h_d;
  logic [WIDTH-1:0] tmo_q, tmo_d;
  logic [WIDTH-1:0] last_p_q, last_p_d;
  logic [WIDTH-1:0] last_h_q, last_h_d;
  logic             have_last_q, have_last_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;
  logic             publish;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      cnt_p_q     <= '0;
      cnt_h_q     <= '0;
      tmo_q       <= '0;
      last_p_q    <= '0;
      last_h_q    <= '0;
      have_last_q <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_p_q     <= cnt_p_d;
      cnt_h_q     <= cnt_h_d;
      tmo_q       <= tmo_d;
      last_p_q    <= last_p_d;
      last_h_q    <= last_h_d;
      have_last_q <= have_last_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  // tmo counts cycles since the last rise, the rise cycle itself being 0, so
  // it tracks cnt_p exactly. Firing when it would step onto CNT_MAX keeps
  // cnt_p from ever exceeding CNT_MAX-1; a rise in that same cycle wins.
  assign timeout = ~rise && (tmo_q >= TMO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_p_d     = cnt_p_q;
    cnt_h_d     = cnt_h_q;
    tmo_d       = (tmo_q == CNT_MAX) ? tmo_q : tmo_q + CNT_ONE;
    last_p_d    = last_p_q;
    last_h_d    = last_h_q;
    have_last_d = have_last_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    stuck_d     = 1'b0;
    stuck_lvl_d = stuck_lvl_q;
    publish     = 1'b0;

    if (rise) begin
      tmo_d = CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (sync_ok && !sync) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (rise) begin
          state_d = ST_MEAS;
          cnt_p_d = CNT_ONE;
          cnt_h_d = CNT_ONE;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          publish = 1'b1;
          cnt_p_d = CNT_ONE;
          cnt_h_d = CNT_ONE;
        end else begin
          cnt_p_d = cnt_p_q + CNT_ONE;
          cnt_h_d = cnt_h_q + {{(WIDTH-1){1'b0}}, sync};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The first result after reset or timeout only seeds the comparison pair.
    if (publish) begin
      period_d    = cnt_p_q;
      high_d      = cnt_h_q;
      valid_d     = 1'b1;
      locked_d    = have_last_q && (cnt_p_q == last_p_q) && (cnt_h_q == last_h_q);
      last_p_d    = cnt_p_q;
      last_h_d    = cnt_h_q;
      have_last_d = 1'b1;
    end

    if (timeout) begin
      state_d     = ST_IDLE;
      tmo_d       = '0;
      cnt_p_d     = '0;
      cnt_h_d     = '0;
      stuck_d     = 1'b1;
      stuck_lvl_d = sync;
      period_d    = '0;
      high_d      = '0;
      locked_d    = 1'b0;
      have_last_d = 1'b0;
    end
  end

  assign meas.period_out  = period_q;
  assign meas.high_out    = high_q;
  assign meas.meas_valid  = valid_q;
  assign meas.locked      = locked_q;
  assign meas.stuck       = stuck_q;
  assign meas.stuck_level = stuck_lvl_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a table of PWM periods with hand-computed results,
// followed by stuck-high, reset and latency sequences.
module tb_pwm_capture;

  localparam int WIDTH = 8;
  localparam int EW    = 2 * WIDTH + 2;
  localparam int NV    = 18;

  logic       clk;
  logic       srst;
  logic       pwm_in;
  logic [1:0] state_dbg;

  pwm_capture_if #(.WIDTH(WIDTH)) meas ();

  pwm_capture #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .pwm_in   (pwm_in),
    .meas     (meas.master),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: {chk_gap, locked, period, high} per expected publish
  logic [EW-1:0] exp_q[$];
  logic [0:0]    stuck_q[$];
  int            last_valid_cyc = -100;
  int            last_stuck_cyc = -100;

  task automatic expect_pub(input int p, input int h, input logic lk, input logic gap);
    exp_q.push_back({gap, lk, WIDTH'(p), WIDTH'(h)});
  endtask

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (meas.meas_valid) begin
      check("valid_stuck_exclusive", {31'd0, meas.stuck}, 32'd0);
      check("valid_not_back_to_back", {31'd0, (cyc == last_valid_cyc + 1)}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_publish", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("period_out", {24'd0, meas.period_out}, {24'd0, e[2*WIDTH-1:WIDTH]});
        check("high_out", {24'd0, meas.high_out}, {24'd0, e[WIDTH-1:0]});
        check("locked", {31'd0, meas.locked}, {31'd0, e[EW-2]});
        if (e[EW-1]) begin
          check("publish_spacing", cyc - last_valid_cyc, {24'd0, e[2*WIDTH-1:WIDTH]});
        end
      end
      last_valid_cyc = cyc;
    end
    if (meas.stuck) begin
      if (stuck_q.size() == 0) begin
        check("unexpected_stuck", 32'd1, 32'd0);
      end else begin
        check("stuck_level", {31'd0, meas.stuck_level}, {31'd0, stuck_q.pop_front()});
        check("period_on_stuck", {24'd0, meas.period_out}, 32'd0);
        check("high_on_stuck", {24'd0, meas.high_out}, 32'd0);
        check("locked_on_stuck", {31'd0, meas.locked}, 32'd0);
      end
      last_stuck_cyc = cyc;
    end
  end

  // driver: hold pwm_in at v for n sampling edges; called just after a posedge
  int rise_drv = 0;

  task automatic hold(input logic v, input int n);
    if (v && !pwm_in) rise_drv = cyc;
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int   h;
    int   l;
    logic pub;
    int   exp_p;
    int   exp_h;
    logic exp_lock;
    logic gap;
    logic tmo;
    logic tmo_lvl;
  } vec_t;

  vec_t vecs[NV];
  int   t_rise;

  initial begin
    srst   = 1'b1;
    pwm_in = 1'b0;

    // one row per driven period; its result appears at the next rising edge
    vecs[0]  = '{5,   5,   1'b1, 10,  5,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5,   5,   1'b1, 10,  5,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{5,   5,   1'b1, 10,  5,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{5,   5,   1'b1, 10,  5,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6,   4,   1'b1, 10,  6,   1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{6,   4,   1'b1, 10,  6,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1,   99,  1'b1, 100, 1,   1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1,   99,  1'b1, 100, 1,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1,   1,   1'b1, 2,   1,   1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1,   1,   1'b1, 2,   1,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1,   1,   1'b1, 2,   1,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3,   7,   1'b1, 10,  3,   1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{100, 154, 1'b1, 254, 100, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{100, 154, 1'b1, 254, 100, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{100, 155, 1'b0, 0,   0,   1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{4,   6,   1'b0, 0,   0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{5,   5,   1'b1, 10,  5,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{5,   5,   1'b1, 10,  5,   1'b1, 1'b1, 1'b0, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_period_out", {24'd0, meas.period_out}, 32'd0);
    check("rst_high_out", {24'd0, meas.high_out}, 32'd0);
    check("rst_meas_valid", {31'd0, meas.meas_valid}, 32'd0);
    check("rst_locked", {31'd0, meas.locked}, 32'd0);
    check("rst_stuck", {31'd0, meas.stuck}, 32'd0);
    check("rst_stuck_level", {31'd0, meas.stuck_level}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk);
    #1;
    srst = 1'b0;
    hold(1'b0, 5);

    // table-driven periods
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pub) expect_pub(vecs[i].exp_p, vecs[i].exp_h, vecs[i].exp_lock, vecs[i].gap);
      if (vecs[i].tmo) stuck_q.push_back(vecs[i].tmo_lvl);
      hold(1'b1, vecs[i].h);
      hold(1'b0, vecs[i].l);
    end

    // line stuck high for 300 cycles: one stuck pulse 255 cycles after the rise
    stuck_q.push_back(1'b1);
    hold(1'b1, 300);
    t_rise = rise_drv;
    check("stuck_time", last_stuck_cyc, t_rise + 257);
    check("stuck_high_state_idle", {30'd0, state_dbg}, 32'd0);
    check("stuck_high_locked", {31'd0, meas.locked}, 32'd0);
    check("stuck_high_period", {24'd0, meas.period_out}, 32'd0);
    hold(1'b0, 10);

    // after release: arm on the first rise, publish on the second
    expect_pub(10, 5, 1'b0, 1'b0);
    hold(1'b1, 5);
    hold(1'b0, 5);
    expect_pub(10, 5, 1'b1, 1'b1);
    hold(1'b1, 5);
    hold(1'b0, 5);
    expect_pub(10, 5, 1'b1, 1'b1);
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 4);
    check("locked_before_srst", {31'd0, meas.locked}, 32'd1);

    // srst mid-period while the line is high
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    check("srst_period_out", {24'd0, meas.period_out}, 32'd0);
    check("srst_high_out", {24'd0, meas.high_out}, 32'd0);
    check("srst_locked", {31'd0, meas.locked}, 32'd0);
    check("srst_meas_valid", {31'd0, meas.meas_valid}, 32'd0);
    check("srst_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk);
    #1;
    hold(1'b1, 20);
    hold(1'b0, 5);
    hold(1'b1, 3);
    hold(1'b0, 4);
    expect_pub(7, 3, 1'b0, 1'b0);
    hold(1'b1, 3);
    t_rise = rise_drv;
    hold(1'b0, 4);
    check("publish_latency", last_valid_cyc, t_rise + 3);
    hold(1'b0, 10);

    check("exp_q_drained", exp_q.size(), 32'd0);
    check("stuck_q_drained", stuck_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
